// File: rtl/ccir_pkg.sv
// ----------------------------------------------------------------------------
// ccir_pkg
// Shared types and constants for the YCbCr -> RGB conversion pipeline.
//   yuv_mode_t : output format selector carried with every beat
//   coefKr/coefKgb/coefKgr/coefKb : BT.601 coefficients scaled to Q(frac)
//   KR, KGB, KGR, KB : the same coefficients at the default 8 fractional bits
// ----------------------------------------------------------------------------
package ccir_pkg;

   typedef enum logic [1:0] {
      MODE_LUMA   = 2'd0,
      MODE_RGB565 = 2'd1,
      MODE_RGB666 = 2'd2,
      MODE_RGB888 = 2'd3
   } yuv_mode_t;

   // Rounds numer/denom * 2^frac to the nearest integer; the real-valued
   // coefficients are expressed as exact ratios so the result is reproducible.
   function automatic int coefScale(input longint numer, input longint denom,
                                    input int frac);
      longint scaled;
      scaled = (numer << frac) + (denom / 64'sd2);
      return int'(scaled / denom);
   endfunction

   function automatic int coefKr(input int frac);
      return coefScale(64'sd1402, 64'sd1000, frac);
   endfunction

   function automatic int coefKgb(input int frac);
      return coefScale(64'sd344136, 64'sd1000000, frac);
   endfunction

   function automatic int coefKgr(input int frac);
      return coefScale(64'sd714136, 64'sd1000000, frac);
   endfunction

   function automatic int coefKb(input int frac);
      return coefScale(64'sd1772, 64'sd1000, frac);
   endfunction

   localparam int FRAC_DEFAULT = 8;
   localparam int KR  = coefKr(FRAC_DEFAULT);
   localparam int KGB = coefKgb(FRAC_DEFAULT);
   localparam int KGR = coefKgr(FRAC_DEFAULT);
   localparam int KB  = coefKb(FRAC_DEFAULT);

endpackage

// File: rtl/yuv_clamp.sv
// ----------------------------------------------------------------------------
// yuv_clamp
// Saturates a signed intermediate colour component into the unsigned
// range [0, 2^DW-1].
//   val_i  : signed component, IW bits
//   val_o  : clamped unsigned component, DW bits
//   clip_o : high when saturation changed the value
// ----------------------------------------------------------------------------
module yuv_clamp #(
   parameter int DW = 8,
   parameter int IW = DW + 3
) (
   input  logic signed [IW-1:0] val_i,
   output logic        [DW-1:0] val_o,
   output logic                 clip_o
);

   localparam logic signed [IW-1:0] MAX_VAL = {{(IW-DW){1'b0}}, {DW{1'b1}}};

   // Negative check first so the upper compare only ever sees non-negative values.
   always_comb begin
      val_o  = val_i[DW-1:0];
      clip_o = 1'b0;
      if (val_i[IW-1]) begin
         val_o  = '0;
         clip_o = 1'b1;
      end else if (val_i > MAX_VAL) begin
         val_o  = '1;
         clip_o = 1'b1;
      end
   end

endmodule

// File: rtl/ycbcr_rgb_pipe.sv
// ----------------------------------------------------------------------------
// ycbcr_rgb_pipe
// Three-stage YCbCr -> RGB converter with valid/ready handshaking on both
// sides and a single global stage enable.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   valid_i, ready_o          : input beat handshake
//   y_i, cb_i, cr_i           : luma and offset-binary chroma samples
//   mode_i                    : output format, travels with its beat
//   valid_o, ready_i          : output result handshake
//   pix_o, clip_o             : packed pixel and saturation flag
// Stage 1 removes the chroma offset, stage 2 applies the constant
// multiplies, stage 3 adds luma, clamps and packs into the requested format.
// ----------------------------------------------------------------------------
module ycbcr_rgb_pipe
   import ccir_pkg::*;
#(
   parameter int DW   = 8,
   parameter int FRAC = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [DW-1:0]   y_i,
   input  logic [DW-1:0]   cb_i,
   input  logic [DW-1:0]   cr_i,
   input  yuv_mode_t       mode_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [3*DW-1:0] pix_o,
   output logic            clip_o
);

   // PW holds a signed coefficient (FRAC+2 bits) times a signed chroma value
   // (DW+1 bits) plus one extra bit for the two-product green sum.
   localparam int PW = DW + FRAC + 4;
   localparam int SW = DW + 3;

   localparam logic signed [PW-1:0] KR_W    = PW'(coefKr(FRAC));
   localparam logic signed [PW-1:0] KGB_W   = PW'(coefKgb(FRAC));
   localparam logic signed [PW-1:0] KGR_W   = PW'(coefKgr(FRAC));
   localparam logic signed [PW-1:0] KB_W    = PW'(coefKb(FRAC));
   localparam logic signed [PW-1:0] ROUND_W = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic        [DW:0]   HALF    = {2'b01, {(DW-1){1'b0}}};

   logic en;

   logic                 valid1_q;
   logic [DW-1:0]        y1_q;
   logic signed [DW:0]   cbS1_q, crS1_q;
   logic signed [DW:0]   cbS_d, crS_d;
   yuv_mode_t            mode1_q;

   logic                 valid2_q;
   logic [DW-1:0]        y2_q;
   logic signed [SW-1:0] dR2_q, dG2_q, dB2_q;
   logic signed [SW-1:0] dR_d, dG_d, dB_d;
   logic signed [PW-1:0] cbExt, crExt, sumR, sumG, sumB;
   yuv_mode_t            mode2_q;

   logic                 valid3_q;
   logic [3*DW-1:0]      pix_q, pix_d;
   logic                 clip_q, clip_d;
   logic signed [SW-1:0] yExt, rSum, gSum, bSum;
   logic [DW-1:0]        rClamp, gClamp, bClamp;
   logic                 rClip, gClip, bClip;

   // A stalled output freezes the whole pipeline; bubbles are kept in place.
   assign en      = !valid3_q || ready_i;
   assign ready_o = en;

   // Stage 1 combinational part: offset-binary chroma to signed.
   always_comb begin
      cbS_d = $signed({1'b0, cb_i}) - $signed(HALF);
      crS_d = $signed({1'b0, cr_i}) - $signed(HALF);
   end

   // Stage 1 register: luma, signed chroma and the beat's mode.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid1_q <= 1'b0;
         y1_q     <= '0;
         cbS1_q   <= '0;
         crS1_q   <= '0;
         mode1_q  <= MODE_LUMA;
      end else if (en) begin
         valid1_q <= valid_i;
         y1_q     <= y_i;
         cbS1_q   <= cbS_d;
         crS1_q   <= crS_d;
         mode1_q  <= mode_i;
      end
   end

   // Stage 2 combinational part: constant multiplies with round-half-up,
   // arithmetic shift back to integer scale.
   always_comb begin
      cbExt = {{(PW-DW-1){cbS1_q[DW]}}, cbS1_q};
      crExt = {{(PW-DW-1){crS1_q[DW]}}, crS1_q};
      sumR  = KR_W * crExt + ROUND_W;
      sumG  = KGB_W * cbExt + KGR_W * crExt + ROUND_W;
      sumB  = KB_W * cbExt + ROUND_W;
      dR_d  = SW'(sumR >>> FRAC);
      dG_d  = SW'(sumG >>> FRAC);
      dB_d  = SW'(sumB >>> FRAC);
   end

   // Stage 2 register: chroma contributions per colour channel.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid2_q <= 1'b0;
         y2_q     <= '0;
         dR2_q    <= '0;
         dG2_q    <= '0;
         dB2_q    <= '0;
         mode2_q  <= MODE_LUMA;
      end else if (en) begin
         valid2_q <= valid1_q;
         y2_q     <= y1_q;
         dR2_q    <= dR_d;
         dG2_q    <= dG_d;
         dB2_q    <= dB_d;
         mode2_q  <= mode1_q;
      end
   end

   // Stage 3: add luma and saturate each channel.
   always_comb begin
      yExt = {3'b000, y2_q};
      rSum = yExt + dR2_q;
      gSum = yExt - dG2_q;
      bSum = yExt + dB2_q;
   end

   yuv_clamp #(.DW(DW), .IW(SW)) clampR (.val_i(rSum), .val_o(rClamp), .clip_o(rClip));
   yuv_clamp #(.DW(DW), .IW(SW)) clampG (.val_i(gSum), .val_o(gClamp), .clip_o(gClip));
   yuv_clamp #(.DW(DW), .IW(SW)) clampB (.val_i(bSum), .val_o(bClamp), .clip_o(bClip));

   // Narrow formats keep the clamped MSBs (plain truncation); luma-only
   // bypasses the colour path entirely, so it never reports clipping.
   always_comb begin
      pix_d  = '0;
      clip_d = rClip | gClip | bClip;
      case (mode2_q)
         MODE_LUMA: begin
            pix_d  = {y2_q, y2_q, y2_q};
            clip_d = 1'b0;
         end
         MODE_RGB565: pix_d[15:0] = {rClamp[DW-1 -: 5], gClamp[DW-1 -: 6], bClamp[DW-1 -: 5]};
         MODE_RGB666: pix_d[17:0] = {rClamp[DW-1 -: 6], gClamp[DW-1 -: 6], bClamp[DW-1 -: 6]};
         MODE_RGB888: pix_d       = {rClamp, gClamp, bClamp};
         default:     pix_d       = '0;
      endcase
   end

   // Stage 3 register drives the outputs directly.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid3_q <= 1'b0;
         pix_q    <= '0;
         clip_q   <= 1'b0;
      end else if (en) begin
         valid3_q <= valid2_q;
         pix_q    <= pix_d;
         clip_q   <= clip_d;
      end
   end

   assign valid_o = valid3_q;
   assign pix_o   = pix_q;
   assign clip_o  = clip_q;

endmodule

// File: tb/tb_ycbcr_rgb_pipe.sv
// ----------------------------------------------------------------------------
// tb_ycbcr_rgb_pipe
// Self-checking bench for ycbcr_rgb_pipe at DW=8, FRAC=8. A negedge monitor
// pushes the reference result of every accepted beat into a queue and
// compares it with every delivered result; scenario tasks add their own
// directed checks on top.
// ----------------------------------------------------------------------------
module tb_ycbcr_rgb_pipe;
   import ccir_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  y_i, cb_i, cr_i;
   yuv_mode_t   mode_i;
   logic        valid_o;
   logic        ready_i;
   logic [23:0] pix_o;
   logic        clip_o;

   int total = 0;
   int bad = 0;
   int resultsSeen = 0;
   logic [24:0] sb[$];
   logic [24:0] expResult;

   always #5 clk_i = ~clk_i;

   ycbcr_rgb_pipe #(.DW(8), .FRAC(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .y_i(y_i), .cb_i(cb_i), .cr_i(cr_i), .mode_i(mode_i),
      .valid_o(valid_o), .ready_i(ready_i), .pix_o(pix_o), .clip_o(clip_o)
   );

   // Reference conversion in plain integer arithmetic; returns {clip, pix}.
   function automatic logic [24:0] model(input int y, input int cb, input int cr,
                                         input logic [1:0] mode);
      int cbs, crs, dr, dg, db, r, g, b;
      bit clip;
      logic [7:0] r8, g8, b8, y8;
      logic [23:0] pix;
      cbs = cb - 128;
      crs = cr - 128;
      dr = (359 * crs + 128) >>> 8;
      dg = (88 * cbs + 183 * crs + 128) >>> 8;
      db = (454 * cbs + 128) >>> 8;
      r = y + dr;
      g = y - dg;
      b = y + db;
      clip = 1'b0;
      if (r < 0) begin r = 0; clip = 1'b1; end else if (r > 255) begin r = 255; clip = 1'b1; end
      if (g < 0) begin g = 0; clip = 1'b1; end else if (g > 255) begin g = 255; clip = 1'b1; end
      if (b < 0) begin b = 0; clip = 1'b1; end else if (b > 255) begin b = 255; clip = 1'b1; end
      r8 = r[7:0];
      g8 = g[7:0];
      b8 = b[7:0];
      y8 = y[7:0];
      case (mode)
         2'd0: begin pix = {y8, y8, y8}; clip = 1'b0; end
         2'd1: pix = {8'h00, r8[7:3], g8[7:2], b8[7:3]};
         2'd2: pix = {6'h00, r8[7:2], g8[7:2], b8[7:2]};
         default: pix = {r8, g8, b8};
      endcase
      return {clip, pix};
   endfunction

   // Scoreboard monitor: push on accepted beats, pop and compare on delivered results.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (valid_i && ready_o)
            sb.push_back(model(int'(y_i), int'(cb_i), int'(cr_i), mode_i));
         if (valid_o && ready_i) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("[TB] FAIL sb_unexpected: got pix=%h clip=%b, required no result", pix_o, clip_o);
            end else begin
               expResult = sb.pop_front();
               resultsSeen++;
               if ({clip_o, pix_o} !== expResult) begin
                  bad++;
                  $display("[TB] FAIL sb_result: got pix=%h clip=%b, required pix=%h clip=%b",
                           pix_o, clip_o, expResult[23:0], expResult[24]);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic syncDrive();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sendBeat(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                           input yuv_mode_t mode);
      bit accepted;
      accepted = 1'b0;
      valid_i = 1'b1;
      y_i = y;
      cb_i = cb;
      cr_i = cr;
      mode_i = mode;
      for (int i = 0; i < 200 && !accepted; i++) begin
         @(negedge clk_i);
         accepted = ready_o;
         @(posedge clk_i);
         #1;
      end
      if (!accepted) begin
         total++;
         bad++;
         $display("[TB] FAIL accept_timeout: got ready_o=0 for 200 cycles, required acceptance");
      end
   endtask

   task automatic idleInput();
      valid_i = 1'b0;
   endtask

   task automatic waitValid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (valid_o) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drainScoreboard(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++)
         @(negedge clk_i);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL %s_drain: got %0d results outstanding, required 0", name, sb.size());
      end
      syncDrive();
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      y_i = '0; cb_i = '0; cr_i = '0;
      mode_i = MODE_LUMA;
      #3;
      total++;
      if ({valid_o, pix_o, clip_o} !== 26'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got valid=%b pix=%h clip=%b, required all zero", valid_o, pix_o, clip_o);
      end
      repeat (3) syncDrive();
      rst_i = 1'b0;
      @(negedge clk_i);
      total++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_release: got ready_o=%b valid_o=%b, required ready_o=1 valid_o=0", ready_o, valid_o);
      end
      syncDrive();
      ready_i = 1'b1;
   endtask

   task automatic test_latency();
      logic [2:0] seen;
      sendBeat(8'd100, 8'd90, 8'd170, MODE_RGB888);
      idleInput();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         seen[i] = valid_o;
      end
      total++;
      if (seen !== 3'b100) begin
         bad++;
         $display("[TB] FAIL latency: got valid_o per cycle (c3,c2,c1)=%b, required 100", seen);
      end
      drainScoreboard("latency");
   endtask

   task automatic test_known_vectors();
      logic [7:0]  vy[3]  = '{8'd128, 8'd255, 8'd16};
      logic [7:0]  vcb[3] = '{8'd128, 8'd128, 8'd128};
      logic [7:0]  vcr[3] = '{8'd128, 8'd255, 8'd0};
      logic [23:0] vpix[3] = '{24'h808080, 24'hFFA4FF, 24'h006B10};
      logic        vclip[3] = '{1'b0, 1'b1, 1'b1};
      bit ok;
      for (int k = 0; k < 3; k++) begin
         sendBeat(vy[k], vcb[k], vcr[k], MODE_RGB888);
         idleInput();
         waitValid(ok);
         total++;
         if (!ok || pix_o !== vpix[k] || clip_o !== vclip[k]) begin
            bad++;
            $display("[TB] FAIL vector%0d: got valid=%b pix=%h clip=%b, required pix=%h clip=%b",
                     k, ok, pix_o, clip_o, vpix[k], vclip[k]);
         end
         syncDrive();
      end
      drainScoreboard("vectors");
   endtask

   task automatic test_mode_switch();
      bit ok;
      sendBeat(8'd128, 8'd128, 8'd128, MODE_RGB565);
      sendBeat(8'd77, 8'd200, 8'd30, MODE_LUMA);
      idleInput();
      waitValid(ok);
      total++;
      if (!ok || pix_o !== 24'h008410 || clip_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mode_rgb565: got valid=%b pix=%h clip=%b, required pix=008410 clip=0", ok, pix_o, clip_o);
      end
      @(negedge clk_i);
      total++;
      if (valid_o !== 1'b1 || pix_o !== 24'h4D4D4D || clip_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mode_luma_next: got valid=%b pix=%h clip=%b, required valid=1 pix=4D4D4D clip=0", valid_o, pix_o, clip_o);
      end
      drainScoreboard("mode_switch");
   endtask

   task automatic test_stall();
      int startSeen;
      int unstable;
      logic [24:0] hold;
      startSeen = resultsSeen;
      unstable = 0;
      fork
         begin
            for (int k = 0; k < 6; k++)
               sendBeat(8'(20 + 30 * k), 8'(60 + 25 * k), 8'(200 - 20 * k), yuv_mode_t'(k % 4));
            idleInput();
         end
         begin
            repeat (4) @(posedge clk_i);
            #1;
            ready_i = 1'b0;
            hold = {clip_o, pix_o};
            for (int i = 0; i < 5; i++) begin
               @(negedge clk_i);
               if (valid_o !== 1'b1 || ready_o !== 1'b0 || {clip_o, pix_o} !== hold)
                  unstable++;
            end
            @(posedge clk_i);
            #1;
            ready_i = 1'b1;
         end
      join
      total++;
      if (unstable != 0) begin
         bad++;
         $display("[TB] FAIL stall_hold: got %0d unstable stall cycles, required 0", unstable);
      end
      drainScoreboard("stall");
      repeat (3) @(negedge clk_i);
      total++;
      if (resultsSeen - startSeen != 6 || valid_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL stall_count: got %0d results valid_o=%b, required 6 results valid_o=0",
                  resultsSeen - startSeen, valid_o);
      end
      syncDrive();
   endtask

   task automatic test_reset_inflight();
      int stale;
      stale = 0;
      sendBeat(8'd50, 8'd100, 8'd150, MODE_RGB888);
      sendBeat(8'd60, 8'd110, 8'd160, MODE_RGB666);
      sendBeat(8'd70, 8'd120, 8'd170, MODE_RGB565);
      idleInput();
      total++;
      if (valid_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL inflight_pre: got valid_o=%b, required 1", valid_o);
      end
      #2;
      rst_i = 1'b1;
      #1;
      total++;
      if (valid_o !== 1'b0 || pix_o !== 24'h0 || clip_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL inflight_async: got valid=%b pix=%h clip=%b, required all zero", valid_o, pix_o, clip_o);
      end
      sb.delete();
      repeat (2) syncDrive();
      rst_i = 1'b0;
      total++;
      if (ready_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL inflight_ready: got ready_o=%b, required 1", ready_o);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         if (valid_o !== 1'b0) stale++;
      end
      total++;
      if (stale != 0) begin
         bad++;
         $display("[TB] FAIL inflight_stale: got %0d cycles with valid_o=1, required 0", stale);
      end
      syncDrive();
      sendBeat(8'd200, 8'd40, 8'd220, MODE_RGB888);
      idleInput();
      drainScoreboard("post_reset");
   endtask

   task automatic test_back_to_back();
      bit driverDone;
      driverDone = 1'b0;
      fork
         begin
            for (int k = 0; k < 60; k++) begin
               sendBeat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)), yuv_mode_t'($urandom_range(0, 3)));
               if ($urandom_range(0, 4) == 0) begin
                  idleInput();
                  syncDrive();
               end
            end
            idleInput();
            driverDone = 1'b1;
         end
         begin
            while (!driverDone) begin
               @(posedge clk_i);
               #1;
               ready_i = ($urandom_range(0, 3) != 0);
            end
            ready_i = 1'b1;
         end
      join
      drainScoreboard("back_to_back");
   endtask

   initial begin
      test_reset();
      test_latency();
      test_known_vectors();
      test_mode_switch();
      test_stall();
      test_reset_inflight();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ycbcr_rgb_pipe.md
YCBCR_RGB_PIPE -- requirements
Module: ycbcr_rgb_pipe

Interface
REQ-001 Parameter DW, default 8, meaning component width in bits; legal range 8..12.
REQ-002 Parameter FRAC, default 8, meaning fractional bits of the fixed-point coefficients.
REQ-003 clk_i  input  1  single clock; all state on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 valid_i  input  1  an input beat is present.
REQ-006 ready_o  output  1  the block accepts a beat this cycle.
REQ-007 y_i, cb_i, cr_i  input  DW each  luma and chroma samples, unsigned, offset-binary chroma.
REQ-008 mode_i  input  2  output format for this beat, type yuv_mode_t: 0 luma_only, 1 rgb565, 2 rgb666, 3 rgb888.
REQ-009 valid_o  output  1  pix_o/clip_o hold a result.
REQ-010 ready_i  input  1  downstream accepts the result.
REQ-011 pix_o  output  3*DW  packed result.
REQ-012 clip_o  output  1  at least one component of this result was saturated.

Function
REQ-013 A beat transfers on valid_i&&ready_o; a result transfers on valid_o&&ready_i.
REQ-014 Pipeline is 3 stages with a global enable en = !valid_o || ready_i; ready_o = en combinationally.
REQ-015 Latency is exactly 3 enabled cycles from input transfer to valid_o; throughput is 1 beat/cycle while ready_i=1.
REQ-016 When en=0, every stage holds, and pix_o, clip_o and valid_o stay stable.
REQ-017 Bubbles are not collapsed; per-stage valid bits advance only with en.
REQ-018 mode_i is captured with its beat and travels with it; a mode change between beats takes effect per beat, without draining.
REQ-019 Stage 1: Cb' = cb_i - 2^(DW-1), Cr' = cr_i - 2^(DW-1), both signed DW+1 bits; register Y, Cb', Cr' and mode.
REQ-020 Stage 2: products with signed coefficients in Q(FRAC) (FRAC=8: KR=359, KGB=88, KGR=183, KB=454); register dR = (KR*Cr' + 2^(FRAC-1)) >>> FRAC, dG = (KGB*Cb' + KGR*Cr' + 2^(FRAC-1)) >>> FRAC, dB = (KB*Cb' + 2^(FRAC-1)) >>> FRAC.
REQ-021 Stage 3: R=Y+dR, G=Y-dG, B=Y+dB, computed at DW+3 signed bits; each is clamped to [0, 2^DW-1]; clip_o=1 if any clamp acted.
REQ-022 In luma_only mode, R=G=B=Y, and clip_o=0.
REQ-023 Packing for rgb888: pix_o={R,G,B}, each DW bits.
REQ-024 Packing for rgb565: low 16 bits = {R[DW-1:DW-5], G[DW-1:DW-6], B[DW-1:DW-5]}, upper bits zero.
REQ-025 Packing for rgb666: low 18 bits = {R[DW-1:DW-6], G[DW-1:DW-6], B[DW-1:DW-6]}, upper bits zero.
REQ-026 Packing for luma_only: pix_o={Y,Y,Y}.
REQ-027 Truncation to narrower formats takes place after clamping; no rounding is applied.
REQ-028 An input beat accepted while the output is stalled is impossible by construction (ready_o=0); no beat is lost or duplicated; order is preserved.

Reset
REQ-029 rst_i asserted immediately clears all stage valid bits, so valid_o=0, pix_o=0 and clip_o=0, independent of clk_i.
REQ-030 Data pipeline registers reset to 0; in-flight beats are discarded on reset mid-operation.
REQ-031 After rst_i deassertion, ready_o=1 on the first cycle (valid_o=0).

Structure
REQ-032 Package ccir_pkg holds the yuv_mode_t enum and the coefficient localparams KR, KGB, KGR, KB (as functions of FRAC).
REQ-033 Sub-module yuv_clamp (signed input, DW-bit unsigned output, clip flag) is instantiated three times in stage 3.
REQ-034 No multicycle paths; all multiplies are by constants and complete in stage 2.

Verification (DW=8, FRAC=8)
REQ-035 Y=128, Cb=128, Cr=128, rgb888 -> after 3 cycles pix_o=24'h808080, clip_o=0.
REQ-036 Y=255, Cb=128, Cr=255, rgb888 -> R=255 (clipped), G=164, B=255, clip_o=1.
REQ-037 Y=16, Cb=128, Cr=0, rgb888 -> R=0 (clipped), G=107, B=16, clip_o=1.
REQ-038 Y=128, Cb=Cr=128, rgb565 -> pix_o=24'h008410; the following beat uses luma_only with Y=77 -> pix_o=24'h4D4D4D on the next cycle.
REQ-039 Stream 6 beats and hold ready_i=0 for 5 cycles mid-stream -> ready_o=0 while valid_o=1; outputs are stable; all 6 results arrive in order, none lost or duplicated.
REQ-040 Assert rst_i asynchronously with 3 beats in flight -> valid_o=0 and pix_o=0 before the next clock edge; no stale result after release.
